// File: rtl/display_pkg.sv
// Constants and types shared by the sprite renderers and the compositor.
// Everything here is pixel-format or sync-bundle level; no logic lives here.
package display_pkg;

    localparam int PIXEL_W = 24;

    typedef logic [PIXEL_W-1:0] pixel_t;

    localparam pixel_t TRANSPARENT = 24'h000000;
    localparam pixel_t BLACK       = 24'h000000;

    // hsync/vsync are active-low; blank is high outside the visible area.
    typedef struct packed {
        logic hsync;
        logic vsync;
        logic blank;
    } sync_t;

    localparam sync_t SYNC_IDLE = '{hsync: 1'b1, vsync: 1'b1, blank: 1'b1};

    function automatic logic is_opaque(input pixel_t px);
        return px != TRANSPARENT;
    endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Fixed-depth shift register used to line timing signals up with a pixel pipeline.
// Every stage resets to RESET_VAL so the far end reads idle until real data arrives.
module sync_delay_line #(
    parameter int               DEPTH     = 3,
    parameter int               WIDTH     = 3,
    parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
    input  logic             pixel_clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] delayed
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign delayed = data;
        end else begin : g_shift
            logic [WIDTH-1:0] stage [DEPTH];

            // NOTE: these are timing registers, not storage, so each stage takes the
            // reset value; a RAM-style unreset array would leak stale sync after reset.
            always_ff @(posedge pixel_clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int k = 0; k < DEPTH; k++) stage[k] <= RESET_VAL;
                end else begin
                    stage[0] <= data;
                    for (int k = 1; k < DEPTH; k++) stage[k] <= stage[k-1];
                end
            end

            assign delayed = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/sprite_compositor.sv
// Merges registered sprite pixel streams by fixed priority over a background colour,
// realigns hsync/vsync/blank to the renderer latency and drives a frame-based blink.
module sprite_compositor
    import display_pkg::*;
#(
    parameter int LAYERS       = 4,
    parameter int SYNC_DELAY   = 3,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                      pixel_clk,
    input  logic                      reset_n,
    input  logic                      hsync_in,
    input  logic                      vsync_in,
    input  logic                      blank_in,
    input  logic [PIXEL_W*LAYERS-1:0] layer_pixels,
    input  logic [LAYERS-1:0]         layer_blink,
    input  logic [PIXEL_W-1:0]        bg_color,
    output logic [PIXEL_W-1:0]        pixel_out,
    output logic                      hsync_out,
    output logic                      vsync_out,
    output logic                      blank_out,
    output logic                      frame_tick
);

    localparam int               CNT_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

    sync_t            sync_in;
    sync_t            sync_dly;
    sync_t            sync_q;
    pixel_t           pixel_next;
    logic             vsync_fall;
    logic [CNT_W-1:0] frame_cnt;
    logic             blink_phase;

    assign sync_in = '{hsync: hsync_in, vsync: vsync_in, blank: blank_in};

    sync_delay_line #(
        .DEPTH     (SYNC_DELAY),
        .WIDTH     ($bits(sync_t)),
        .RESET_VAL (SYNC_IDLE)
    ) u_sync_delay (
        .pixel_clk (pixel_clk),
        .reset_n   (reset_n),
        .data      (sync_in),
        .delayed   (sync_dly)
    );

    // Walking from the lowest priority upward lets the last hit (lowest index) win.
    always_comb begin
        // NOTE: default first so every path assigns pixel_next and no latch is inferred.
        pixel_next = bg_color;
        for (int i = LAYERS - 1; i >= 0; i--) begin
            if (is_opaque(layer_pixels[i*PIXEL_W +: PIXEL_W]) &&
                !(blink_phase && layer_blink[i])) begin
                pixel_next = layer_pixels[i*PIXEL_W +: PIXEL_W];
            end
        end
        if (sync_dly.blank) pixel_next = BLACK;
    end

    // sync_q holds the previous delayed vsync, so this fires on the aligned frame start.
    assign vsync_fall = sync_q.vsync && !sync_dly.vsync;

    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (vsync_fall) begin
            if (frame_cnt == CNT_LAST) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                // NOTE: sequential state always uses non-blocking assignment.
                frame_cnt <= frame_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            pixel_out  <= BLACK;
            sync_q     <= SYNC_IDLE;
            frame_tick <= 1'b0;
        end else begin
            pixel_out  <= pixel_next;
            sync_q     <= sync_dly;
            frame_tick <= vsync_fall;
        end
    end

    assign hsync_out = sync_q.hsync;
    assign vsync_out = sync_q.vsync;
    assign blank_out = sync_q.blank;

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor: a history-based reference model checked every
// cycle, plus hand-computed expectations for priority, blank, alignment and blink.
module tb_sprite_compositor;

    localparam int LAYERS = 4;
    localparam int SD     = 3;
    localparam int BF     = 2;

    logic                 pixel_clk    = 1'b0;
    logic                 reset_n      = 1'b0;
    logic                 hsync_in     = 1'b1;
    logic                 vsync_in     = 1'b1;
    logic                 blank_in     = 1'b1;
    logic [24*LAYERS-1:0] layer_pixels = '0;
    logic [LAYERS-1:0]    layer_blink  = '0;
    logic [23:0]          bg_color     = '0;
    logic [23:0]          pixel_out;
    logic                 hsync_out;
    logic                 vsync_out;
    logic                 blank_out;
    logic                 frame_tick;

    int n_vec  = 0;
    int n_fail = 0;

    sprite_compositor #(
        .LAYERS       (LAYERS),
        .SYNC_DELAY   (SD),
        .BLINK_FRAMES (BF)
    ) dut (
        .pixel_clk    (pixel_clk),
        .reset_n      (reset_n),
        .hsync_in     (hsync_in),
        .vsync_in     (vsync_in),
        .blank_in     (blank_in),
        .layer_pixels (layer_pixels),
        .layer_blink  (layer_blink),
        .bg_color     (bg_color),
        .pixel_out    (pixel_out),
        .hsync_out    (hsync_out),
        .vsync_out    (vsync_out),
        .blank_out    (blank_out),
        .frame_tick   (frame_tick)
    );

    always #5 pixel_clk = ~pixel_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [24*LAYERS-1:0] pix;
        logic [LAYERS-1:0]    mask;
        logic [23:0]          bg;
        logic                 hs;
        logic                 vs;
        logic                 bl;
    } in_t;

    in_t  hist[$];
    int   m_ticks;
    logic m_prev_vs;
    int   k;
    logic s_hs, s_vs, s_bl, exp_tick;
    logic [23:0] exp_pix;

    function automatic logic [23:0] model_pixel(input in_t e, input logic phase);
        logic [23:0] p;
        for (int i = 0; i < LAYERS; i++) begin
            p = e.pix[i*24 +: 24];
            if (p != 24'h0 && !(phase && e.mask[i])) return p;
        end
        return e.bg;
    endfunction

    // Inputs change only on negedges; this process samples them at the posedge and
    // checks the DUT just after it against the model.
    always @(posedge pixel_clk) begin
        if (!reset_n) begin
            hist.delete();
            m_ticks   = 0;
            m_prev_vs = 1'b1;
            #1;
            check("m_rst_pixel", pixel_out, 24'h0);
            check("m_rst_hsync", hsync_out, 1'b1);
            check("m_rst_vsync", vsync_out, 1'b1);
            check("m_rst_blank", blank_out, 1'b1);
            check("m_rst_tick", frame_tick, 1'b0);
        end else begin
            hist.push_back('{pix: layer_pixels, mask: layer_blink, bg: bg_color,
                             hs: hsync_in, vs: vsync_in, bl: blank_in});
            k = hist.size() - 1;
            #1;
            s_hs = 1'b1; s_vs = 1'b1; s_bl = 1'b1;
            if (k >= SD) begin
                s_hs = hist[k-SD].hs;
                s_vs = hist[k-SD].vs;
                s_bl = hist[k-SD].bl;
            end
            exp_pix  = s_bl ? 24'h0 : model_pixel(hist[k], ((m_ticks / BF) % 2) == 1);
            exp_tick = m_prev_vs && !s_vs;
            check("m_pixel", pixel_out, exp_pix);
            check("m_hsync", hsync_out, s_hs);
            check("m_vsync", vsync_out, s_vs);
            check("m_blank", blank_out, s_bl);
            check("m_tick", frame_tick, exp_tick);
            if (exp_tick) m_ticks++;
            m_prev_vs = s_vs;
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic hs, input logic vs, input logic bl);
        @(negedge pixel_clk);
        hsync_in = hs;
        vsync_in = vs;
        blank_in = bl;
    endtask

    task automatic set_layers(input logic [23:0] l0, input logic [23:0] l1,
                              input logic [23:0] l2, input logic [23:0] l3);
        layer_pixels = {l3, l2, l1, l0};
    endtask

    task automatic do_reset(input int cycles);
        @(negedge pixel_clk);
        reset_n = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge pixel_clk);
            check("rst_pixel", pixel_out, 24'h0);
            check("rst_syncs", {hsync_out, vsync_out, blank_out}, 3'b111);
            check("rst_tick", frame_tick, 1'b0);
        end
        reset_n = 1'b1;
    endtask

    // Frame of 12 cycles: vsync low for 2, blank for 4, then 8 visible pixels.
    // Returns the pixel seen late in the visible region and the ticks counted.
    task automatic run_frame(output logic [23:0] late_pix, output int ticks);
        ticks = 0;
        for (int c = 0; c < 12; c++) begin
            drive(1'b1, !(c < 2), c < 4);
            if (frame_tick) ticks++;
        end
        late_pix = pixel_out;
    endtask

    logic [23:0] blink_exp [6] = '{24'h0000FF, 24'h111111, 24'h111111,
                                   24'h0000FF, 24'h0000FF, 24'h111111};
    logic [23:0] post_exp  [3] = '{24'h0000FF, 24'h111111, 24'h111111};

    initial begin
        logic [23:0] lp;
        int          t, total;

        // Reset with random inputs.
        for (int i = 0; i < 5; i++) begin
            @(negedge pixel_clk);
            hsync_in     = 1'($urandom);
            vsync_in     = 1'($urandom);
            blank_in     = 1'($urandom);
            layer_pixels = {$urandom, $urandom, $urandom};
            layer_blink  = 4'($urandom);
            bg_color     = 24'($urandom);
            check("rst_pixel", pixel_out, 24'h0);
            check("rst_syncs", {hsync_out, vsync_out, blank_out}, 3'b111);
            check("rst_tick", frame_tick, 1'b0);
        end

        // Release; outputs follow inputs after SD+1 cycles; priority layer1 over layer2.
        @(negedge pixel_clk);
        reset_n = 1'b1;
        hsync_in = 1'b1; vsync_in = 1'b1; blank_in = 1'b0;
        set_layers(24'h0, 24'hFF0000, 24'h00FF00, 24'h0);
        layer_blink = 4'b0000;
        bg_color    = 24'h102030;
        for (int i = 0; i < 4; i++) begin
            @(negedge pixel_clk);
            check("release_blank", blank_out, (i < 3) ? 1'b1 : 1'b0);
        end
        check("priority_l1", pixel_out, 24'hFF0000);

        drive(1'b1, 1'b1, 1'b0);
        set_layers(24'h0, 24'h0, 24'h0, 24'h0);
        @(negedge pixel_clk);
        check("background", pixel_out, 24'h102030);

        // Blank override: pixel forced to black exactly while blank_out is high.
        drive(1'b1, 1'b1, 1'b1);
        set_layers(24'hFFFFFF, 24'h00FF00, 24'h0, 24'h0);
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b1, 1'b0);
            check("blank_out_pulse", blank_out, i == 3);
            check("blank_override", pixel_out, (i == 3) ? 24'h0 : 24'hFFFFFF);
        end

        // Sync alignment: single-cycle hsync, then vsync pulses.
        drive(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b1, 1'b0);
            check("hsync_align", hsync_out, i != 3);
        end
        drive(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b1, 1'b0);
            check("vsync_align", vsync_out, i != 3);
            check("tick_align", frame_tick, i == 3);
        end

        // Mid-frame reset, then the blink sequence from a clean counter.
        do_reset(2);
        layer_blink = 4'b0001;
        set_layers(24'h0000FF, 24'h0, 24'h0, 24'h0);
        bg_color = 24'h111111;
        for (int i = 0; i < 6; i++) drive(1'b1, 1'b1, 1'b0);
        check("blink_preframe", pixel_out, 24'h0000FF);

        total = 0;
        for (int f = 0; f < 6; f++) begin
            run_frame(lp, t);
            total += t;
            check("blink_frame", lp, blink_exp[f]);
        end
        check("blink_tick_count", total, 6);

        // Reset while blink_phase is 1: layer 0 visible again, counter restarted.
        do_reset(2);
        for (int i = 0; i < 6; i++) drive(1'b1, 1'b1, 1'b0);
        check("post_rst_visible", pixel_out, 24'h0000FF);
        for (int f = 0; f < 3; f++) begin
            run_frame(lp, t);
            check("post_rst_frame", lp, post_exp[f]);
            check("post_rst_tick", t, 1);
        end

        // Mid-frame mask change takes effect immediately (phase is 1 now).
        drive(1'b1, 1'b1, 1'b0);
        layer_blink = 4'b0000;
        @(negedge pixel_clk);
        check("mask_change", pixel_out, 24'h0000FF);

        repeat (2) @(negedge pixel_clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
